// File: rtl/mod47_frame_acc_if.sv
// Token/result stream bundle for mod47_frame_acc: an input residue stream and an output frame-sum stream.
// The master drives tokens and consumes results; the slave (the accumulator) does the reverse.
interface mod47_frame_acc_if;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/mod47_frame_acc.sv
// Sums FRAME_LEN mod-47 residues per frame and holds the result until taken or discarded.
// Define MOD47_RANGE_CHECK_EN to flag (and skip) tokens in 47..63 on the err port instead of folding them.
module mod47_frame_acc #(
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  mod47_frame_acc_if.slave  bus
`ifdef MOD47_RANGE_CHECK_EN
  ,
  output logic              err
`endif
);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(FRAME_LEN - 1);

  state_t     state_r;
  state_t     state_nx;
  logic [5:0] acc_r;
  logic [5:0] acc_nx;
  logic [7:0] cnt_r;
  logic [7:0] cnt_nx;
  logic [5:0] out_data_r;
  logic [5:0] out_data_nx;
  logic [5:0] sum_s;
`ifdef MOD47_RANGE_CHECK_EN
  logic       err_r;
  logic       err_nx;
`endif

  // Fold a 6-bit token into 0..46; upstream stages only overshoot by less than one modulus.
  function automatic logic [5:0] reduce_token(input logic [5:0] tok);
    logic [5:0] r;
    if (tok >= 6'd47) begin
      r = tok - 6'd47;
    end else begin
      r = tok;
    end
    return r;
  endfunction

  // Both operands are already below 47, so one conditional subtract completes the reduction.
  function automatic logic [5:0] add_mod47(input logic [5:0] a, input logic [5:0] b);
    logic [6:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 7'd47) begin
      s = s - 7'd47;
    end else begin
      s = s;
    end
    return s[5:0];
  endfunction

`ifdef MOD47_RANGE_CHECK_EN
  function automatic logic token_in_range(input logic [5:0] tok);
    return (tok < 6'd47);
  endfunction
`endif

  // Candidate accumulator value if the offered token is taken.
  always_comb begin
    sum_s = add_mod47(acc_r, reduce_token(bus.in_data));
  end

  // Next-state, datapath and flag decode.
  always_comb begin
    state_nx    = state_r;
    acc_nx      = acc_r;
    cnt_nx      = cnt_r;
    out_data_nx = out_data_r;
`ifdef MOD47_RANGE_CHECK_EN
    err_nx      = 1'b0;
`endif
    case (state_r)
      ST_ACC: begin
        if (clr) begin
          acc_nx = 6'd0;
          cnt_nx = 8'd0;
        end else if (bus.in_valid) begin
`ifdef MOD47_RANGE_CHECK_EN
          if (!token_in_range(bus.in_data)) begin
            err_nx = 1'b1;
          end else begin
`else
          begin
`endif
            acc_nx = sum_s;
            cnt_nx = cnt_r + 8'd1;
            if (cnt_r == LAST_CNT) begin
              state_nx    = ST_HOLD;
              out_data_nx = sum_s;
            end else begin
              state_nx    = ST_ACC;
            end
          end
        end else begin
          state_nx = ST_ACC;
        end
      end
      ST_HOLD: begin
        // clr wins over out_ready: either way the frame is dropped and the next one starts clean.
        if (clr || bus.out_ready) begin
          state_nx    = ST_ACC;
          acc_nx      = 6'd0;
          cnt_nx      = 8'd0;
          out_data_nx = 6'd0;
        end else begin
          state_nx    = ST_HOLD;
        end
      end
      default: begin
        state_nx    = ST_ACC;
        acc_nx      = 6'd0;
        cnt_nx      = 8'd0;
        out_data_nx = 6'd0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_ACC;
      acc_r      <= 6'd0;
      cnt_r      <= 8'd0;
      out_data_r <= 6'd0;
`ifdef MOD47_RANGE_CHECK_EN
      err_r      <= 1'b0;
`endif
    end else begin
      state_r    <= state_nx;
      acc_r      <= acc_nx;
      cnt_r      <= cnt_nx;
      out_data_r <= out_data_nx;
`ifdef MOD47_RANGE_CHECK_EN
      err_r      <= err_nx;
`endif
    end
  end

  assign bus.in_ready  = (state_r == ST_ACC) && !rst;
  assign bus.out_valid = (state_r == ST_HOLD);
  assign bus.out_data  = out_data_r;
`ifdef MOD47_RANGE_CHECK_EN
  assign err           = err_r;
`endif

endmodule

// File: tb/tb_mod47_frame_acc.sv
// Randomized + known-answer bench for mod47_frame_acc against a queue-based frame-sum model.
// Honours MOD47_RANGE_CHECK_EN the same way the design does.
module tb_mod47_frame_acc;

  localparam int FL = 8;
`ifdef MOD47_RANGE_CHECK_EN
  localparam int MAXTOK = 46;
`else
  localparam int MAXTOK = 63;
`endif

  logic clk;
  logic rst;
  logic clr;
`ifdef MOD47_RANGE_CHECK_EN
  logic err;
  logic err1;
`endif

  mod47_frame_acc_if bus ();
  mod47_frame_acc_if bus1 ();

  mod47_frame_acc #(.FRAME_LEN(FL)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
`ifdef MOD47_RANGE_CHECK_EN
    ,
    .err (err)
`endif
  );

  mod47_frame_acc #(.FRAME_LEN(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .bus (bus1)
`ifdef MOD47_RANGE_CHECK_EN
    ,
    .err (err1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;
  int got_q[$];

  // reference model: list of counted residues in the open frame, plus a held result
  int m_frame[$];
  bit m_hold   = 0;
  int m_result = 0;
  bit m_err    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step(input bit r, input bit c, input bit v, input int d, input bit ordy);
    int s;
    m_err = 0;
    if (r) begin
      m_frame.delete();
      m_hold   = 0;
      m_result = 0;
    end else if (m_hold) begin
      if (c || ordy) begin
        m_hold   = 0;
        m_result = 0;
        m_frame.delete();
      end
    end else if (c) begin
      m_frame.delete();
    end else if (v) begin
      if (d >= 47) begin
`ifdef MOD47_RANGE_CHECK_EN
        m_err = 1;
`else
        m_frame.push_back(d - 47);
`endif
      end else begin
        m_frame.push_back(d);
      end
      if (m_frame.size() == FL) begin
        s = 0;
        foreach (m_frame[i]) s += m_frame[i];
        m_result = s % 47;
        m_hold   = 1;
      end
    end
  endfunction

  task automatic cycle(input bit r, input bit c, input bit v, input int d, input bit ordy);
    rst = r;
    clr = c;
    bus.in_valid  = v;
    bus.in_data   = 6'(d);
    bus.out_ready = ordy;
    #1;
    if (chk_en) begin
      check_eq("in_ready", bus.in_ready, (!m_hold && !r) ? 1 : 0);
      check_eq("out_valid", bus.out_valid, m_hold ? 1 : 0);
      check_eq("out_data", bus.out_data, m_hold ? m_result : 0);
`ifdef MOD47_RANGE_CHECK_EN
      check_eq("err", err, m_err ? 1 : 0);
`endif
      if (bus.out_valid === 1'b1 && ordy && !c && !r) got_q.push_back(int'(bus.out_data));
    end
    @(posedge clk);
    model_step(r, c, v, d, ordy);
    #1;
  endtask

  task automatic frame_of(input int tok, input bit drain);
    for (int i = 0; i < FL; i++) cycle(0, 0, 1, tok, 0);
    if (drain) cycle(0, 0, 0, 0, 1);
  endtask

  task automatic expect_result(input string tag, input int exp);
    int g;
    g = (got_q.size() > 0) ? got_q.pop_front() : -1;
    check_eq(tag, g, exp);
  endtask

  initial begin
    int d;
    int s;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = 6'd0;
    bus1.out_ready = 1'b0;

    // reset: first cycle unchecked (state unknown before the first edge)
    cycle(1, 0, 0, 0, 0);
    chk_en = 1;
    cycle(1, 0, 1, 3, 1);
    cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // tokens 0..7 back-to-back
    for (int i = 0; i < FL; i++) cycle(0, 0, 1, i, 1);
    cycle(0, 0, 0, 0, 1);
    expect_result("kat_0to7", 28);

    frame_of(46, 1);
    expect_result("kat_46x8", 39);

    // stall in HOLD for 5 cycles with tokens offered, then release
    s = 0;
    for (int i = 0; i < FL; i++) begin
      d = $urandom_range(0, 46);
      s += d;
      cycle(0, 0, 1, d, 0);
    end
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 7, 0);
    cycle(0, 0, 1, 7, 1);
    cycle(0, 0, 0, 0, 0);
    expect_result("stall_sum", s % 47);

    // out-of-range token handling
`ifdef MOD47_RANGE_CHECK_EN
    cycle(0, 0, 1, 50, 0);
    cycle(0, 0, 1, 10, 0);
    cycle(0, 0, 1, 20, 0);
    for (int i = 0; i < FL - 2; i++) cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1);
    expect_result("range_chk", 30);
`else
    cycle(0, 0, 1, 50, 0);
    cycle(0, 0, 1, 10, 0);
    for (int i = 0; i < FL - 2; i++) cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1);
    expect_result("range_fold", 13);
`endif

    // reset mid-frame
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 5, 0);
    cycle(1, 0, 0, 0, 0);
    frame_of(1, 0);
    check_eq("no_early", got_q.size(), 0);
    cycle(0, 0, 0, 0, 1);
    expect_result("rst_mid", FL % 47);

    // reset while holding a result
    frame_of(9, 0);
    cycle(1, 0, 0, 0, 1);
    check_eq("rst_hold", got_q.size(), 0);

    // clr together with out_ready in HOLD drops the result
    frame_of(3, 0);
    cycle(0, 1, 0, 0, 1);
    check_eq("clr_hold", got_q.size(), 0);
    frame_of(2, 1);
    expect_result("after_clr", 16);

    // clr in ACC with a token offered
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 9, 0);
    cycle(0, 1, 1, 9, 0);
    frame_of(4, 1);
    expect_result("clr_acc", 32);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 63),
            ($urandom_range(0, 2) == 0));
    end
    got_q.delete();
    cycle(0, 0, 0, 0, 0);

    // FRAME_LEN=1 instance: every token becomes its own result
    for (int i = 0; i < 20; i++) begin
      d = $urandom_range(0, MAXTOK);
      bus1.in_valid  = 1'b1;
      bus1.in_data   = 6'(d);
      bus1.out_ready = 1'b1;
      #1;
      check_eq("fl1_rdy", bus1.in_ready, 1);
      @(posedge clk);
      #1;
      bus1.in_valid = 1'b0;
      check_eq("fl1_vld", bus1.out_valid, 1);
      check_eq("fl1_data", bus1.out_data, (d >= 47) ? d - 47 : d);
      @(posedge clk);
      #1;
      check_eq("fl1_idle", bus1.out_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
